// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizer, debounce FSM, registered level and rise/fall pulses.
// Define AUTO_REPEAT_EN to re-pulse btn_rise every REPEAT_CYCLES while the button stays held.
module btn_debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    // state      | meaning
    // IDLE_LOW   | released level accepted, waiting for a press
    // WAIT_HIGH  | press seen, counting stable high samples
    // HELD_HIGH  | pressed level accepted (auto-repeat timer runs here if enabled)
    // WAIT_LOW   | release seen, counting stable low samples
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int CNT_MAX = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_btn_s;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                w_cnt_nxt = '0;
                if (w_btn_s) begin
                    // With a single-sample window the first sample is already the accepted one.
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = HELD_HIGH;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = HELD_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD_HIGH: begin
                if (!w_btn_s) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE_LOW;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (r_cnt == REPEAT_LAST) begin
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            WAIT_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt = HELD_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_CYCLES=8.
// Expected auto-repeat pulses follow AUTO_REPEAT_EN, the same macro the design uses.
module tb_btn_debounce_pulse;

    logic clk;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic       b;
        logic [2:0] exp;   // {level, rise, fall}
    } vec_t;

    vec_t vecs[$];

    btn_debounce_pulse #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {level,rise,fall}=%b expected %b", name, act, exp);
    endtask

    task automatic step(input logic b, input logic [2:0] exp, input string name);
        btn_in = b;
        @(posedge clk);
        #1;
        check(name, {btn_level, btn_rise, btn_fall}, exp);
    endtask

    task automatic add(input logic b, input logic [2:0] e, input int n);
        vec_t v;
        v.b   = b;
        v.exp = e;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        logic       ar;
        logic [2:0] e;
`ifdef AUTO_REPEAT_EN
        ar = 1'b1;
`else
        ar = 1'b0;
`endif
        // Press held: level/rise after edge 6.
        add(1'b1, 3'b000, 5); add(1'b1, 3'b110, 1); add(1'b1, 3'b100, 1);
        // Release held: fall after the 6th edge of low input.
        add(1'b0, 3'b100, 5); add(1'b0, 3'b001, 1); add(1'b0, 3'b000, 1);
        // One-cycle glitch from IDLE_LOW: nothing happens.
        add(1'b1, 3'b000, 1); add(1'b0, 3'b000, 19);
        // Bounce 1,1,1,0 then held: accepted 6 edges after the final rise.
        add(1'b1, 3'b000, 3); add(1'b0, 3'b000, 1); add(1'b1, 3'b000, 5);
        add(1'b1, 3'b110, 1); add(1'b1, 3'b100, 1);

        reset  = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {btn_level, btn_rise, btn_fall}, 3'b000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Async reset while HELD_HIGH: level must drop before the next edge.
        #3 reset = 1'b1;
        #1 check("async_rst_held", {btn_level, btn_rise, btn_fall}, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reach WAIT_HIGH, then reset mid-cycle with the button still pressed.
        for (int k = 1; k <= 4; k++)
            step(1'b1, 3'b000, $sformatf("pre_rst_wait%0d", k));
        #3 reset = 1'b1;
        #1 check("async_rst_wait", {btn_level, btn_rise, btn_fall}, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fresh press after reset, held 30 edges.
        for (int k = 1; k <= 30; k++) begin
            e[2] = (k >= 6);
            e[1] = (k == 6) || (ar && (k == 14 || k == 22 || k == 30));
            e[0] = 1'b0;
            step(1'b1, e, $sformatf("held_edge%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
